// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

    localparam int unsigned CENTS_W = 13;
    localparam int unsigned COIN_W  = 4;

    localparam int unsigned COIN_5_IDX   = 0;
    localparam int unsigned COIN_10_IDX  = 1;
    localparam int unsigned COIN_25_IDX  = 2;
    localparam int unsigned COIN_100_IDX = 3;

    localparam logic [CENTS_W-1:0] COIN_5_VAL   = CENTS_W'(5);
    localparam logic [CENTS_W-1:0] COIN_10_VAL  = CENTS_W'(10);
    localparam logic [CENTS_W-1:0] COIN_25_VAL  = CENTS_W'(25);
    localparam logic [CENTS_W-1:0] COIN_100_VAL = CENTS_W'(100);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAY    = 2'd1,
        VEND   = 2'd2,
        REFUND = 2'd3
    } state_t;

    // Value of a one-hot coin pulse; callers only use it when exactly one bit is set.
    function automatic logic [CENTS_W-1:0] coin_value(input logic [COIN_W-1:0] coin);
        logic [CENTS_W-1:0] v;
        v = '0;
        if (coin[COIN_5_IDX])        v = COIN_5_VAL;
        else if (coin[COIN_10_IDX])  v = COIN_10_VAL;
        else if (coin[COIN_25_IDX])  v = COIN_25_VAL;
        else if (coin[COIN_100_IDX]) v = COIN_100_VAL;
        return v;
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Inactivity down-counter; expired is high once TIMEOUT_CYCLES-1 enabled cycles have elapsed since clear.
module vend_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // expired is kept as a register that mirrors (count == 0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= LOAD;
            expired <= (LOAD == '0);
        end else if (clr) begin
            count   <= LOAD;
            expired <= (LOAD == '0);
        end else if (en && (count != '0)) begin
            count   <= count - CNT_W'(1);
            expired <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction FSM: latches the selected price, accumulates coin credit,
// and finishes with a vend (plus change) or a refund on cancel/timeout.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000000,
    parameter int unsigned MAX_CREDIT     = 8000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel_done,
    input  logic               code_v,
    input  logic [CENTS_W-1:0] price,
    input  logic [COIN_W-1:0]  coin,
    input  logic               cancel,
    output logic [CENTS_W-1:0] credit,
    output logic               busy,
    output logic               coin_reject,
    output logic               err_invalid,
    output logic               vend,
    output logic               refund,
    output logic [CENTS_W-1:0] change,
    output logic               change_valid
);

    state_t             state_q, state_d;
    logic [CENTS_W-1:0] price_q, price_d;
    logic [CENTS_W-1:0] credit_d, change_d, coin_val;
    logic [CENTS_W:0]   credit_sum;
    logic               coin_accept, coin_reject_d, err_invalid_d;
    logic               vend_d, refund_d, busy_d;
    logic               timer_clr, timer_en, timer_expired;

    vend_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    assign coin_val   = coin_value(coin);
    assign credit_sum = (CENTS_W+1)'(credit) + (CENTS_W+1)'(coin_val);

    always_comb begin
        state_d       = state_q;
        price_d       = price_q;
        credit_d      = credit;
        change_d      = change;
        coin_accept   = 1'b0;
        coin_reject_d = 1'b0;
        err_invalid_d = 1'b0;
        timer_clr     = 1'b0;
        timer_en      = 1'b0;

        case (state_q)
            IDLE: begin
                coin_reject_d = |coin;
                if (sel_done) begin
                    if (code_v) begin
                        price_d   = price;
                        timer_clr = 1'b1;
                        state_d   = PAY;
                    end else begin
                        err_invalid_d = 1'b1;
                    end
                end
            end
            PAY: begin
                if (|coin) begin
                    if ($onehot(coin) && (credit_sum <= (CENTS_W+1)'(MAX_CREDIT))) begin
                        coin_accept = 1'b1;
                        credit_d    = credit + coin_val;
                        timer_clr   = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                // Cancel wins over payment; a same-cycle accepted coin is part of the refund
                if (cancel) begin
                    state_d  = REFUND;
                    change_d = credit_d;
                end else if (credit_d >= price_q) begin
                    state_d  = VEND;
                    change_d = credit_d - price_q;
                end else if (timer_expired && !coin_accept) begin
                    state_d  = REFUND;
                    change_d = credit_d;
                end else begin
                    timer_en = !coin_accept;
                end
            end
            VEND, REFUND: begin
                coin_reject_d = |coin;
                credit_d      = '0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        vend_d   = (state_d == VEND);
        refund_d = (state_d == REFUND);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            price_q      <= '0;
            credit       <= '0;
            busy         <= 1'b0;
            coin_reject  <= 1'b0;
            err_invalid  <= 1'b0;
            vend         <= 1'b0;
            refund       <= 1'b0;
            change       <= '0;
            change_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            price_q      <= price_d;
            credit       <= credit_d;
            busy         <= busy_d;
            coin_reject  <= coin_reject_d;
            err_invalid  <= err_invalid_d;
            vend         <= vend_d;
            refund       <= refund_d;
            change       <= change_d;
            change_valid <= vend_d | refund_d;
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed vector table, corner sequences, random vs. model.
module tb_vend_controller;

    localparam int unsigned T_CYC = 16;
    localparam int unsigned MAXC  = 8000;

    logic        clk, rst_n;
    logic        sel_done, code_v, cancel;
    logic [12:0] price;
    logic [3:0]  coin;
    logic [12:0] credit, change;
    logic        busy, coin_reject, err_invalid, vend, refund, change_valid;

    vend_controller #(.TIMEOUT_CYCLES(T_CYC), .MAX_CREDIT(MAXC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel_done     (sel_done),
        .code_v       (code_v),
        .price        (price),
        .coin         (coin),
        .cancel       (cancel),
        .credit       (credit),
        .busy         (busy),
        .coin_reject  (coin_reject),
        .err_invalid  (err_invalid),
        .vend         (vend),
        .refund       (refund),
        .change       (change),
        .change_valid (change_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level reference: in_txn = waiting for payment, closing = 1 vend / 2 refund this cycle
    bit m_in_txn;
    int m_closing, m_credit, m_price, m_idle;
    int x_credit, x_change;
    bit x_busy, x_reject, x_err, x_vend, x_refund, x_cv;
    int coin_cents[4] = '{5, 10, 25, 100};

    typedef struct {
        bit   sd;
        bit   cv;
        int   pr;
        logic [3:0] cn;
        bit   cc;
        int   e_credit;
        bit   e_busy;
        bit   e_vend;
        bit   e_refund;
        bit   e_cv;
        int   e_change;
        bit   e_reject;
        bit   e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit sd, bit cv, int pr, logic [3:0] cn, bit cc,
                                int ecr, bit eb, bit ev, bit er, bit ecv, int ech, bit erj, bit eer);
        vec_t v;
        v.sd = sd; v.cv = cv; v.pr = pr; v.cn = cn; v.cc = cc;
        v.e_credit = ecr; v.e_busy = eb; v.e_vend = ev; v.e_refund = er; v.e_cv = ecv;
        v.e_change = ech; v.e_reject = erj; v.e_err = eer;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_txn = 0; m_closing = 0; m_credit = 0; m_price = 0; m_idle = 0;
        x_credit = 0; x_change = 0; x_busy = 0; x_reject = 0; x_err = 0;
        x_vend = 0; x_refund = 0; x_cv = 0;
    endtask

    task automatic model_step(input bit sd, input bit cv, input int pr, input logic [3:0] cn, input bit cc);
        int  val;
        bit  ok;
        x_reject = 0; x_err = 0; x_vend = 0; x_refund = 0; x_cv = 0;
        if (m_closing != 0) begin
            x_reject  = (cn != 0);
            m_credit  = 0;
            m_closing = 0;
        end else if (!m_in_txn) begin
            x_reject = (cn != 0);
            if (sd && cv) begin
                m_in_txn = 1; m_price = pr; m_idle = 0;
            end else if (sd) begin
                x_err = 1;
            end
        end else begin
            val = 0;
            for (int i = 0; i < 4; i++) if (cn[i]) val += coin_cents[i];
            ok = ($countones(cn) == 1) && (m_credit + val <= int'(MAXC));
            if (cn != 0 && !ok) x_reject = 1;
            if (ok) begin
                m_credit += val;
                m_idle = 0;
            end
            if (cc) m_closing = 2;
            else if (m_credit >= m_price) m_closing = 1;
            else if (!ok && m_idle == int'(T_CYC) - 1) m_closing = 2;
            else if (!ok) m_idle++;
            if (m_closing != 0) begin
                m_in_txn = 0;
                x_cv     = 1;
                x_vend   = (m_closing == 1);
                x_refund = (m_closing == 2);
                x_change = (m_closing == 1) ? m_credit - m_price : m_credit;
            end
        end
        x_credit = m_credit;
        x_busy   = m_in_txn || (m_closing != 0);
    endtask

    task automatic drive(input bit sd, input bit cv, input int pr, input logic [3:0] cn, input bit cc);
        @(negedge clk);
        sel_done = sd; code_v = cv; price = 13'(pr); coin = cn; cancel = cc;
        model_step(sd, cv, pr, cn, cc);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".credit"},       int'(credit),       x_credit);
        chk({tag, ".busy"},         int'(busy),         int'(x_busy));
        chk({tag, ".vend"},         int'(vend),         int'(x_vend));
        chk({tag, ".refund"},       int'(refund),       int'(x_refund));
        chk({tag, ".change_valid"}, int'(change_valid), int'(x_cv));
        chk({tag, ".change"},       int'(change),       x_change);
        chk({tag, ".coin_reject"},  int'(coin_reject),  int'(x_reject));
        chk({tag, ".err_invalid"},  int'(err_invalid),  int'(x_err));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".credit"},       int'(credit),       0);
        chk({tag, ".busy"},         int'(busy),         0);
        chk({tag, ".vend"},         int'(vend),         0);
        chk({tag, ".refund"},       int'(refund),       0);
        chk({tag, ".change_valid"}, int'(change_valid), 0);
        chk({tag, ".change"},       int'(change),       0);
        chk({tag, ".coin_reject"},  int'(coin_reject),  0);
        chk({tag, ".err_invalid"},  int'(err_invalid),  0);
    endtask

    initial begin
        int n;
        bit seen;
        logic [3:0] rc;
        int r;

        rst_n = 1'b0; sel_done = 0; code_v = 0; price = '0; coin = '0; cancel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors: expected outputs after the edge that samples the inputs
        vecs.push_back(mk(1,1,100,4'b0000,0,   0,1,0,0,0,  0,0,0));
        vecs.push_back(mk(0,0,  0,4'b0100,0,  25,1,0,0,0,  0,0,0));
        vecs.push_back(mk(0,0,  0,4'b0100,0,  50,1,0,0,0,  0,0,0));
        vecs.push_back(mk(0,0,  0,4'b0100,0,  75,1,0,0,0,  0,0,0));
        vecs.push_back(mk(0,0,  0,4'b0100,0, 100,1,1,0,1,  0,0,0));
        vecs.push_back(mk(0,0,  0,4'b0000,0,   0,0,0,0,0,  0,0,0));
        vecs.push_back(mk(1,1, 75,4'b0000,0,   0,1,0,0,0,  0,0,0));
        vecs.push_back(mk(0,0,  0,4'b1000,0, 100,1,1,0,1, 25,0,0));
        vecs.push_back(mk(0,0,  0,4'b0000,0,   0,0,0,0,0, 25,0,0));
        vecs.push_back(mk(1,0, 50,4'b0000,0,   0,0,0,0,0, 25,0,1));
        vecs.push_back(mk(0,0,  0,4'b0100,0,   0,0,0,0,0, 25,1,0));
        vecs.push_back(mk(0,0,  0,4'b0000,1,   0,0,0,0,0, 25,0,0));
        vecs.push_back(mk(1,1,125,4'b0000,0,   0,1,0,0,0, 25,0,0));
        vecs.push_back(mk(0,0,  0,4'b0100,0,  25,1,0,0,0, 25,0,0));
        vecs.push_back(mk(0,0,  0,4'b0010,0,  35,1,0,0,0, 25,0,0));
        vecs.push_back(mk(0,0,  0,4'b0000,1,  35,1,0,1,1, 35,0,0));
        vecs.push_back(mk(0,0,  0,4'b0000,0,   0,0,0,0,0, 35,0,0));
        vecs.push_back(mk(1,1,125,4'b0000,0,   0,1,0,0,0, 35,0,0));
        vecs.push_back(mk(0,0,  0,4'b0100,0,  25,1,0,0,0, 35,0,0));
        vecs.push_back(mk(0,0,  0,4'b0010,0,  35,1,0,0,0, 35,0,0));
        vecs.push_back(mk(0,0,  0,4'b0001,1,  40,1,0,1,1, 40,0,0));
        vecs.push_back(mk(0,0,  0,4'b0000,0,   0,0,0,0,0, 40,0,0));
        vecs.push_back(mk(1,1, 10,4'b0000,0,   0,1,0,0,0, 40,0,0));
        vecs.push_back(mk(0,0,  0,4'b0010,0,  10,1,1,0,1,  0,0,0));
        vecs.push_back(mk(0,0,  0,4'b0001,0,   0,0,0,0,0,  0,1,0));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].sd, vecs[i].cv, vecs[i].pr, vecs[i].cn, vecs[i].cc);
            chk({tag, ".credit"},       int'(credit),       vecs[i].e_credit);
            chk({tag, ".busy"},         int'(busy),         int'(vecs[i].e_busy));
            chk({tag, ".vend"},         int'(vend),         int'(vecs[i].e_vend));
            chk({tag, ".refund"},       int'(refund),       int'(vecs[i].e_refund));
            chk({tag, ".change_valid"}, int'(change_valid), int'(vecs[i].e_cv));
            chk({tag, ".change"},       int'(change),       vecs[i].e_change);
            chk({tag, ".coin_reject"},  int'(coin_reject),  int'(vecs[i].e_reject));
            chk({tag, ".err_invalid"},  int'(err_invalid),  int'(vecs[i].e_err));
        end

        // Timeout: one 10c coin, then refund expected on the 16th idle cycle
        drive(1, 1, 100, 4'b0000, 0); check_model("to_sel");
        drive(0, 0, 0, 4'b0010, 0);   check_model("to_coin");
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            drive(0, 0, 0, 4'b0000, 0);
            n++;
            check_model("to_idle");
            seen = refund;
        end
        chk("timeout_idle_cycles", n, 16);
        chk("timeout_change", int'(change), 10);
        drive(0, 0, 0, 4'b0000, 0); check_model("to_exit");

        // Two coin bits set in PAY: rejected, credit held
        drive(1, 1, 100, 4'b0000, 0); check_model("mb_sel");
        drive(0, 0, 0, 4'b0100, 0);   check_model("mb_coin");
        drive(0, 0, 0, 4'b0011, 0);   check_model("mb_multi");
        chk("multibit_reject", int'(coin_reject), 1);
        chk("multibit_credit", int'(credit), 25);
        drive(0, 0, 0, 4'b0000, 1);   check_model("mb_cancel");
        drive(0, 0, 0, 4'b0000, 0);   check_model("mb_exit");

        // Credit ceiling: 80 dollar coins reach MAX_CREDIT, the next 5c is refused
        drive(1, 1, 8191, 4'b0000, 0); check_model("ov_sel");
        for (int i = 0; i < 80; i++) begin
            drive(0, 0, 0, 4'b1000, 0); check_model("ov_fill");
        end
        drive(0, 0, 0, 4'b0001, 0);   check_model("ov_over");
        chk("overflow_reject", int'(coin_reject), 1);
        chk("overflow_credit", int'(credit), 8000);
        drive(0, 0, 0, 4'b0000, 1);   check_model("ov_cancel");
        chk("overflow_refund", int'(change), 8000);
        drive(0, 0, 0, 4'b0000, 0);   check_model("ov_exit");

        // Asynchronous reset mid-PAY at credit 50
        drive(1, 1, 100, 4'b0000, 0); check_model("rs_sel");
        drive(0, 0, 0, 4'b0100, 0);   check_model("rs_c1");
        drive(0, 0, 0, 4'b0100, 0);   check_model("rs_c2");
        chk("rs_credit50", int'(credit), 50);
        sel_done = 0; code_v = 0; price = '0; coin = '0; cancel = 0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        @(posedge clk); #1 check_all_zero("rst_held");
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        drive(1, 1, 75, 4'b0000, 0); check_model("rs_new_sel");
        drive(0, 0, 0, 4'b1000, 0);  check_model("rs_new_coin");
        chk("rs_new_vend", int'(vend), 1);
        chk("rs_new_change", int'(change), 25);
        drive(0, 0, 0, 4'b0000, 0);  check_model("rs_new_exit");

        // Random traffic against the reference model
        for (int s = 0; s < 3000; s++) begin
            r = int'($urandom_range(0, 19));
            if (r < 4)       rc = 4'(1 << r);
            else if (r == 4) rc = 4'($urandom_range(0, 15));
            else             rc = 4'b0000;
            drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0),
                  int'($urandom_range(0, 300)), rc, ($urandom_range(0, 39) == 0));
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
